// File: rtl/count_up_nbits_if.sv
// Control and status bundle for count_up_nbits: enable/clear in, count and display out.
interface count_up_nbits_if #(
  parameter int unsigned N = 6
);
  logic         en;
  logic         clear;
  logic [N-1:0] count_out;
  logic         tc;
  logic [6:0]   led1;
  logic [6:0]   led2;
  logic         bcd_busy;

  modport master (
    output en, clear,
    input  count_out, tc, led1, led2, bcd_busy
  );

  modport slave (
    input  en, clear,
    output count_out, tc, led1, led2, bcd_busy
  );
endinterface

// File: rtl/count_up_nbits.sv
// N-bit up-counter with terminal count and a two-digit active-low 7-segment readout
// fed by a multi-cycle double-dabble converter. Option: COUNT_UP_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module count_up_nbits #(
  parameter int unsigned N = 6
) (
  input  logic            clk,
  input  logic            reset,
  count_up_nbits_if.slave bus
);

  localparam int unsigned CW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0]  SEG_ZERO  = 7'b1000000;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
`ifdef COUNT_UP_LEADING_ZERO_BLANK_EN
  localparam logic [6:0]  LED2_RST  = SEG_BLANK;
`else
  localparam logic [6:0]  LED2_RST  = SEG_ZERO;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  count;
  logic [N-1:0]  last_conv;
  logic [N-1:0]  bin;
  logic [3:0]    tens;
  logic [3:0]    units;
  logic [3:0]    units_adj;
  logic [2:0]    tens_adj;
  logic [CW-1:0] shcnt;
  logic          busy;
  logic [6:0]    led1_q;
  logic [6:0]    led2_q;

  // Active-low gfedcba decode; anything above 9 blanks.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Counter: clear beats enable, wraps without saturation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (bus.clear) begin
      count <= '0;
    end else if (bus.en) begin
      count <= count + N'(1);
    end
  end

  // Add-3 correction; the tens nibble never exceeds 6, so its top bit is shifted out.
  always_comb begin
    units_adj = (units >= 4'd5) ? (units + 4'd3) : units;
    tens_adj  = 3'((tens >= 4'd5) ? (tens + 4'd3) : tens);
  end

  // Converter FSM; a count change mid-conversion is picked up on return to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_conv <= '0;
      bin       <= '0;
      tens      <= '0;
      units     <= '0;
      shcnt     <= '0;
      busy      <= 1'b0;
      led1_q    <= SEG_ZERO;
      led2_q    <= LED2_RST;
    end else begin
      case (state)
        IDLE: begin
          if (count != last_conv) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          bin       <= count;
          last_conv <= count;
          tens      <= '0;
          units     <= '0;
          shcnt     <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          {tens, units, bin} <= {tens_adj, units_adj, bin, 1'b0};
          shcnt              <= shcnt + CW'(1);
          if (shcnt == CW'(N - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          led1_q <= seg7(units);
`ifdef COUNT_UP_LEADING_ZERO_BLANK_EN
          led2_q <= (tens == 4'd0) ? SEG_BLANK : seg7(tens);
`else
          led2_q <= seg7(tens);
`endif
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.count_out = count;
  assign bus.tc        = (count == {N{1'b1}});
  assign bus.led1      = led1_q;
  assign bus.led2      = led2_q;
  assign bus.bcd_busy  = busy;

endmodule

// File: tb/tb_count_up_nbits.sv
// Directed bench for count_up_nbits (N=6): reset, counting, display latency, wrap, clear, async reset.
module tb_count_up_nbits;

  localparam int unsigned N = 6;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
`ifdef COUNT_UP_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS0 = 7'b1111111;
`else
  localparam logic [6:0] TENS0 = S0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  count_up_nbits_if #(.N(N)) bus ();
  count_up_nbits #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input logic [5:0] exp_cnt, input logic exp_tc);
    chk({tag, "_count"}, 8'(bus.count_out), 8'(exp_cnt));
    chk({tag, "_tc"}, 8'(bus.tc), 8'(exp_tc));
  endtask

  task automatic chk_disp(input string tag, input logic [6:0] l2, input logic [6:0] l1);
    chk({tag, "_led2"}, 8'(bus.led2), 8'(l2));
    chk({tag, "_led1"}, 8'(bus.led1), 8'(l1));
  endtask

  initial begin
    bus.en    = 1'b0;
    bus.clear = 1'b0;

    // Reset held with clock running, then released
    idle(3);
    chk_cnt("rst_hold", 6'd0, 1'b0);
    chk_disp("rst_hold", TENS0, S0);
    chk("rst_hold_busy", 8'(bus.bcd_busy), 8'd0);
    reset = 1'b1;
    idle(3);
    chk_cnt("rst_rel", 6'd0, 1'b0);
    chk_disp("rst_rel", TENS0, S0);
    chk("rst_rel_busy", 8'(bus.bcd_busy), 8'd0);

    // Count to 36 with slow enables, spot-checking 5 and 15
    for (int i = 1; i <= 36; i++) begin
      pulse();
      idle(10);
      if (i == 5)  chk_disp("cnt5", TENS0, S5);
      if (i == 15) chk_disp("cnt15", S1, S5);
    end

    // 37th increment: display changes exactly 9 edges later
    pulse();
    chk_cnt("cnt37", 6'd37, 1'b0);
    chk("cnt37_busy_e0", 8'(bus.bcd_busy), 8'd0);
    tick();
    chk("cnt37_busy_e1", 8'(bus.bcd_busy), 8'd1);
    idle(7);
    chk_disp("lat_e8", S3, S6);
    tick();
    chk_disp("lat_e9", S3, S7);
    chk("lat_e9_busy", 8'(bus.bcd_busy), 8'd0);
    idle(10);

    // Wrap and terminal count
    for (int i = 0; i < 25; i++) begin
      pulse();
      idle(10);
    end
    chk_cnt("cnt62", 6'd62, 1'b0);
    pulse();
    chk_cnt("cnt63", 6'd63, 1'b1);
    idle(10);
    chk_disp("disp63", S6, S3);
    pulse();
    chk_cnt("wrap0", 6'd0, 1'b0);
    idle(10);
    chk_disp("disp_wrap0", TENS0, S0);

    // Clear has priority over enable
    for (int i = 0; i < 20; i++) begin
      pulse();
      idle(10);
    end
    chk_cnt("cnt20", 6'd20, 1'b0);
    chk_disp("disp20", S2, S0);
    bus.clear = 1'b1;
    bus.en    = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.en    = 1'b0;
    chk_cnt("clr_pri", 6'd0, 1'b0);
    idle(10);
    chk_disp("disp_clr", TENS0, S0);

    // Count changes while a conversion is in flight
    for (int i = 0; i < 8; i++) begin
      pulse();
      idle(10);
    end
    pulse();
    idle(2);
    pulse();
    chk_cnt("cnt10", 6'd10, 1'b0);
    idle(25);
    chk_disp("disp10", S1, S0);

    // Asynchronous reset in the middle of a conversion
    pulse();
    tick();
    chk("mid_busy", 8'(bus.bcd_busy), 8'd1);
    reset = 1'b0;
    #1;
    chk_cnt("arst", 6'd0, 1'b0);
    chk_disp("arst", TENS0, S0);
    chk("arst_busy", 8'(bus.bcd_busy), 8'd0);
    reset = 1'b1;
    idle(12);
    chk_disp("arst_after", TENS0, S0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
